// File: rtl/pipe_pkg.sv
// Shared definitions for the core's pipeline stage registers: NOP encoding,
// per-stage payload widths and the occupancy encoding of elastic_pipe_reg.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Stage payload widths
    localparam int IFID_W  = 64;
    localparam int IDEX_W  = 160;
    localparam int EXMEM_W = 106;
    localparam int MEMWB_W = 71;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_HALF  = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Encoded to match occupancy so the state doubles as the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_HALF  = OCC_HALF,
        ST_FULL  = OCC_FULL
    } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset;
// holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush and saturating stall/bubble performance counters.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    parameter int                 SKID      = 1,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Handshake: a payload moves on a rising edge where valid and ready are
    // both high; the producer may drop valid without a transfer, and data is
    // only looked at on that transferring edge.

    if (SKID != 0) begin : g_skid
        pipe_state_e       state_q, state_d;
        logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
        logic              accept, issue;

        // in_ready comes straight from the state register, cutting the
        // out_ready -> in_ready path between stages.
        assign in_ready  = (state_q != ST_FULL);
        assign out_valid = (state_q != ST_EMPTY);
        assign out_data  = main_q;
        assign occupancy = state_q;
        assign accept    = in_valid & in_ready;
        assign issue     = out_valid & out_ready;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= ST_EMPTY;
                main_q  <= RESET_VAL;
                skid_q  <= RESET_VAL;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
            end
        end

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (flush) begin
                state_d = ST_EMPTY;
                main_d  = RESET_VAL;
                skid_d  = RESET_VAL;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_d  = in_data;
                            state_d = ST_HALF;
                        end
                    end
                    ST_HALF: begin
                        if (accept && issue) begin
                            main_d = in_data;
                        end else if (accept) begin
                            skid_d  = in_data;
                            state_d = ST_FULL;
                        end else if (issue) begin
                            main_d  = RESET_VAL;
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (issue) begin
                            main_d  = skid_q;
                            skid_d  = RESET_VAL;
                            state_d = ST_HALF;
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                        main_d  = RESET_VAL;
                        skid_d  = RESET_VAL;
                    end
                endcase
            end
        end
    end else begin : g_single
        pipe_state_e       state_q, state_d;
        logic [DATA_W-1:0] data_q, data_d;
        logic              accept, issue;

        // Ready looks through to out_ready so a held entry can be replaced
        // on the same edge it leaves.
        assign in_ready  = (state_q == ST_EMPTY) | out_ready;
        assign out_valid = (state_q == ST_HALF);
        assign out_data  = data_q;
        assign occupancy = state_q;
        assign accept    = in_valid & in_ready;
        assign issue     = out_valid & out_ready;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= ST_EMPTY;
                data_q  <= RESET_VAL;
            end else begin
                state_q <= state_d;
                data_q  <= data_d;
            end
        end

        always_comb begin
            state_d = state_q;
            data_d  = data_q;
            if (flush) begin
                state_d = ST_EMPTY;
                data_d  = RESET_VAL;
            end else if (accept) begin
                state_d = ST_HALF;
                data_d  = in_data;
            end else if (issue) begin
                state_d = ST_EMPTY;
                data_d  = RESET_VAL;
            end else if (state_q == ST_FULL) begin
                state_d = ST_EMPTY;
                data_d  = RESET_VAL;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid & ~out_ready),
        .clr (1'b0),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~out_valid & out_ready),
        .clr (1'b0),
        .cnt (bubble_cnt)
    );

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: skid, no-skid and 4-bit-counter instances share
// one input stream and are checked against a queue-based reference model.
module tb_elastic_pipe_reg;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_ready;

    logic          a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
    logic [DW-1:0] a_od, b_od, c_od;
    logic [1:0]    a_occ, b_occ, c_occ;
    logic [15:0]   a_st, a_bu, b_st, b_bu;
    logic [3:0]    c_st, c_bu;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q[3][$];
    int            m_stall[3];
    int            m_bubble[3];

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          fl;
        logic          ordy;
        logic          ov;
        logic [DW-1:0] od;
        logic          ir;
        logic [1:0]    occ;
        logic [15:0]   st;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    elastic_pipe_reg #(.DATA_W(DW), .RESET_VAL('0), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data),
        .flush(flush), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
        .occupancy(a_occ), .stall_cnt(a_st), .bubble_cnt(a_bu)
    );

    elastic_pipe_reg #(.DATA_W(DW), .RESET_VAL('0), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data),
        .flush(flush), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
        .occupancy(b_occ), .stall_cnt(b_st), .bubble_cnt(b_bu)
    );

    elastic_pipe_reg #(.DATA_W(DW), .RESET_VAL('0), .SKID(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ir), .in_data(in_data),
        .flush(flush), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od),
        .occupancy(c_occ), .stall_cnt(c_st), .bubble_cnt(c_bu)
    );

    // ---------------- reference model ----------------
    function automatic int m_max(int d);
        return (d == 2) ? 15 : 65535;
    endfunction

    function automatic bit m_valid(int d);
        return exp_q[d].size() > 0;
    endfunction

    function automatic logic [DW-1:0] m_data(int d);
        return (exp_q[d].size() > 0) ? exp_q[d][0] : '0;
    endfunction

    function automatic bit m_ready(int d);
        if (d == 1) return (exp_q[1].size() == 0) || (out_ready == 1'b1);
        return exp_q[d].size() < 2;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            exp_q[d].delete();
            m_stall[d]  = 0;
            m_bubble[d] = 0;
        end
    endtask

    task automatic model_edge();
        bit v[3];
        bit r[3];
        for (int d = 0; d < 3; d++) begin
            v[d] = m_valid(d);
            r[d] = m_ready(d);
        end
        for (int d = 0; d < 3; d++) begin
            if (v[d] && !out_ready && m_stall[d] < m_max(d)) m_stall[d]++;
            if (!v[d] && out_ready && m_bubble[d] < m_max(d)) m_bubble[d]++;
            if (flush) begin
                exp_q[d].delete();
            end else begin
                if (v[d] && out_ready) void'(exp_q[d].pop_front());
                if (in_valid && r[d]) exp_q[d].push_back(in_data);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic iv, input logic [DW-1:0] id, input logic fl, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_clear();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int d);
        logic [31:0] ov, od, ir, oc, st, bu;
        case (d)
            0: begin ov = 32'(a_ov); od = 32'(a_od); ir = 32'(a_ir); oc = 32'(a_occ); st = 32'(a_st); bu = 32'(a_bu); end
            1: begin ov = 32'(b_ov); od = 32'(b_od); ir = 32'(b_ir); oc = 32'(b_occ); st = 32'(b_st); bu = 32'(b_bu); end
            default: begin ov = 32'(c_ov); od = 32'(c_od); ir = 32'(c_ir); oc = 32'(c_occ); st = 32'(c_st); bu = 32'(c_bu); end
        endcase
        check($sformatf("dut%0d.out_valid", d), ov, 32'(m_valid(d)));
        check($sformatf("dut%0d.out_data", d), od, 32'(m_data(d)));
        check($sformatf("dut%0d.in_ready", d), ir, 32'(m_ready(d)));
        check($sformatf("dut%0d.occupancy", d), oc, 32'(exp_q[d].size()));
        check($sformatf("dut%0d.stall_cnt", d), st, 32'(m_stall[d]));
        check($sformatf("dut%0d.bubble_cnt", d), bu, 32'(m_bubble[d]));
    endtask

    task automatic add(input logic iv, input logic [DW-1:0] id, input logic fl, input logic ordy,
                       input logic ov, input logic [DW-1:0] od, input logic ir,
                       input logic [1:0] occ, input logic [15:0] st);
        vec_t v;
        v.iv = iv; v.id = id; v.fl = fl; v.ordy = ordy;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ; v.st = st;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Skid instance rows: inputs during the cycle | expected pre-edge outputs.
        // streaming 1..4
        add(1'b1, 16'h0001, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b1, 2'd0, 16'd0);
        add(1'b1, 16'h0002, 1'b0, 1'b1,  1'b1, 16'h0001, 1'b1, 2'd1, 16'd0);
        add(1'b1, 16'h0003, 1'b0, 1'b1,  1'b1, 16'h0002, 1'b1, 2'd1, 16'd0);
        add(1'b1, 16'h0004, 1'b0, 1'b1,  1'b1, 16'h0003, 1'b1, 2'd1, 16'd0);
        add(1'b0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'h0004, 1'b1, 2'd1, 16'd0);
        add(1'b0, 16'h0000, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b1, 2'd0, 16'd0);
        // backpressure: A, B, then C waits on the input
        add(1'b1, 16'h000A, 1'b0, 1'b0,  1'b0, 16'h0000, 1'b1, 2'd0, 16'd0);
        add(1'b1, 16'h000B, 1'b0, 1'b0,  1'b1, 16'h000A, 1'b1, 2'd1, 16'd0);
        add(1'b1, 16'h000C, 1'b0, 1'b0,  1'b1, 16'h000A, 1'b0, 2'd2, 16'd1);
        add(1'b1, 16'h000C, 1'b0, 1'b0,  1'b1, 16'h000A, 1'b0, 2'd2, 16'd2);
        add(1'b1, 16'h000C, 1'b0, 1'b1,  1'b1, 16'h000A, 1'b0, 2'd2, 16'd3);
        add(1'b1, 16'h000C, 1'b0, 1'b1,  1'b1, 16'h000B, 1'b1, 2'd1, 16'd3);
        add(1'b0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'h000C, 1'b1, 2'd1, 16'd3);
        add(1'b0, 16'h0000, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b1, 2'd0, 16'd3);
        // flush while full, with a third payload offered on the same edge
        add(1'b1, 16'h001A, 1'b0, 1'b0,  1'b0, 16'h0000, 1'b1, 2'd0, 16'd3);
        add(1'b1, 16'h001B, 1'b0, 1'b0,  1'b1, 16'h001A, 1'b1, 2'd1, 16'd3);
        add(1'b1, 16'h001C, 1'b1, 1'b0,  1'b1, 16'h001A, 1'b0, 2'd2, 16'd4);
        add(1'b0, 16'h0000, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b1, 2'd0, 16'd5);
        add(1'b0, 16'h0000, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b1, 2'd0, 16'd5);
        // flush colliding with accept and issue while half full
        add(1'b1, 16'h002A, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b1, 2'd0, 16'd5);
        add(1'b1, 16'h002B, 1'b1, 1'b1,  1'b1, 16'h002A, 1'b1, 2'd1, 16'd5);
        add(1'b0, 16'h0000, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b1, 2'd0, 16'd5);

        // ---- reset state ----
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        model_clear();
        #2;
        check("reset.out_valid", 32'(a_ov), 32'd0);
        check("reset.out_data", 32'(a_od), 32'd0);
        check("reset.in_ready", 32'(a_ir), 32'd1);
        check("reset.occupancy", 32'(a_occ), 32'd0);
        check("reset.noskid_in_ready", 32'(b_ir), 32'd1);
        do_reset();

        // ---- vector table on the skid instance ----
        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].fl, vecs[i].ordy);
            @(negedge clk);
            check($sformatf("row%0d.out_valid", i), 32'(a_ov), 32'(vecs[i].ov));
            check($sformatf("row%0d.out_data", i), 32'(a_od), 32'(vecs[i].od));
            check($sformatf("row%0d.in_ready", i), 32'(a_ir), 32'(vecs[i].ir));
            check($sformatf("row%0d.occupancy", i), 32'(a_occ), 32'(vecs[i].occ));
            check($sformatf("row%0d.stall_cnt", i), 32'(a_st), 32'(vecs[i].st));
            tick();
        end

        // ---- asynchronous reset with two entries held ----
        drive(1'b1, 16'h00A1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h00A2, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        check("midrst.pre_occupancy", 32'(a_occ), 32'd2);
        check("midrst.pre_in_ready", 32'(a_ir), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst.out_valid", 32'(a_ov), 32'd0);
        check("midrst.out_data", 32'(a_od), 32'd0);
        check("midrst.in_ready", 32'(a_ir), 32'd1);
        check("midrst.occupancy", 32'(a_occ), 32'd0);
        check("midrst.stall_cnt", 32'(a_st), 32'd0);
        check("midrst.bubble_cnt", 32'(a_bu), 32'd0);
        do_reset();

        // ---- single-entry instance: combinational ready, swap on one edge ----
        drive(1'b1, 16'h0055, 1'b0, 1'b0);
        @(negedge clk);
        check("noskid.empty_in_ready", 32'(b_ir), 32'd1);
        check("noskid.empty_out_valid", 32'(b_ov), 32'd0);
        tick();
        drive(1'b1, 16'h0066, 1'b0, 1'b1);
        @(negedge clk);
        check("noskid.hold_out_data", 32'(b_od), 32'h55);
        check("noskid.ready_follows_out_ready", 32'(b_ir), 32'd1);
        out_ready = 1'b0;
        #1;
        check("noskid.ready_drops_same_cycle", 32'(b_ir), 32'd0);
        out_ready = 1'b1;
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("noskid.swap_out_data", 32'(b_od), 32'h66);
        check("noskid.swap_out_valid", 32'(b_ov), 32'd1);
        check("noskid.swap_occupancy", 32'(b_occ), 32'd1);
        tick();
        do_reset();

        // ---- counter saturation on the 4-bit instance ----
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            tick();
            check($sformatf("sat.bubble4_k%0d", k), 32'(c_bu), (k > 15) ? 32'd15 : 32'(k));
            check($sformatf("sat.bubble16_k%0d", k), 32'(a_bu), 32'(k));
        end
        do_reset();

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 3) != 0), DW'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 19) == 0),
                  1'((n % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0)));
            @(negedge clk);
            for (int d = 0; d < 3; d++) check_dut(d);
            tick();
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_dut(d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
